// File: rtl/adder_arbiter_if.sv
// Bus bundle for adder_arbiter: two operand requesters, one result consumer
// and a busy status flag.
interface adder_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_sum;
   logic             res_carry;
   logic             res_id;
   logic             busy;

   // Side that issues operand pairs and consumes results.
   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_sum, res_carry, res_id, busy
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_sum, res_carry, res_id, busy
   );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter in front of one shared WIDTH-bit adder.
// One operation in flight at a time: IDLE accepts, COMPUTE adds, RESULT
// holds the sum until the consumer takes it.
module adder_arbiter #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   adder_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESULT  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             grant0_s;
   logic             grant1_s;
   logic             last_grant_r;
   logic [WIDTH-1:0] op_a_r;
   logic [WIDTH-1:0] op_b_r;
   logic             op_id_r;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] res_sum_r;
   logic             res_carry_r;
   logic             res_id_r;
   logic             res_valid_r;
   logic             busy_r;

   // Grant decision: only in IDLE and never while reset is asserted; a tie
   // goes to the requester that did not win last time.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (!rst && (state_r == IDLE)) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (last_grant_r) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end else if (bus.req0_valid) begin
            grant0_s = 1'b1;
         end else if (bus.req1_valid) begin
            grant1_s = 1'b1;
         end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   assign bus.req0_ready = grant0_s;
   assign bus.req1_ready = grant1_s;

   // The single shared adder; carry lands in the extra top bit.
   assign sum_s = {1'b0, op_a_r} + {1'b0, op_b_r};

   // Next-state logic for the accept / compute / result sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant0_s || grant1_s) begin
               state_nxt_s = COMPUTE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         COMPUTE: begin
            state_nxt_s = RESULT;
         end
         RESULT: begin
            if (res_valid_r && bus.res_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESULT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Busy flag registered from the next state so it tracks state exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
      end
   end

   // Operand capture, result registration and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a_r       <= '0;
         op_b_r       <= '0;
         op_id_r      <= 1'b0;
         last_grant_r <= 1'b1;
         res_sum_r    <= '0;
         res_carry_r  <= 1'b0;
         res_id_r     <= 1'b0;
         res_valid_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant0_s) begin
                  op_a_r       <= bus.req0_a;
                  op_b_r       <= bus.req0_b;
                  op_id_r      <= 1'b0;
                  last_grant_r <= 1'b0;
               end else if (grant1_s) begin
                  op_a_r       <= bus.req1_a;
                  op_b_r       <= bus.req1_b;
                  op_id_r      <= 1'b1;
                  last_grant_r <= 1'b1;
               end
            end
            COMPUTE: begin
               res_sum_r   <= sum_s[WIDTH-1:0];
               res_carry_r <= sum_s[WIDTH];
               res_id_r    <= op_id_r;
               res_valid_r <= 1'b1;
            end
            RESULT: begin
               if (bus.res_ready) begin
                  res_valid_r <= 1'b0;
               end
            end
            default: begin
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.res_valid = res_valid_r;
   assign bus.res_sum   = res_sum_r;
   assign bus.res_carry = res_carry_r;
   assign bus.res_id    = res_id_r;
   assign bus.busy      = busy_r;

endmodule
